// File: rtl/bt_pkg.sv
// Shared definitions for the balanced-ternary result converter: trit codes and FSM states.
package bt_pkg;

    localparam logic [1:0] BT_NEG  = 2'b01;
    localparam logic [1:0] BT_ZERO = 2'b11;
    localparam logic [1:0] BT_POS  = 2'b10;
    localparam logic [1:0] BT_INV  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bt_state_e;

endpackage

// File: rtl/bt_trit_decode.sv
// Maps one 2-bit trit code to its signed value; the invalid code reads as 0 and raises a flag.
module bt_trit_decode
    import bt_pkg::*;
(
    input  logic [1:0]        code,
    output logic signed [1:0] value,
    output logic              invalid
);

    always_comb begin
        value   = 2'sd0;
        invalid = 1'b0;
        case (code)
            BT_NEG:  value = -2'sd1;
            BT_POS:  value = 2'sd1;
            BT_ZERO: value = 2'sd0;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/bt_result_to_binary.sv
// Serial balanced-ternary to two's-complement converter, MSB trit first, one trit per clock.
module bt_result_to_binary
    import bt_pkg::*;
#(
    parameter int unsigned NTRITS = 4,
    parameter int unsigned OUT_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*NTRITS-1:0]     in_trits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_value,
    output logic                    out_err
);

    localparam int unsigned IN_W    = 2 * NTRITS;
    localparam int unsigned CNT_W   = (NTRITS > 1) ? $clog2(NTRITS) : 1;
    localparam int unsigned MAX_MAG = ((3 ** NTRITS) - 1) / 2;
    localparam int unsigned MAX_POS = (1 << (OUT_W - 1)) - 1;

    // Largest word magnitude must fit the signed output, otherwise refuse to elaborate.
    if (MAX_MAG > MAX_POS) begin : g_width_check
        $error("bt_result_to_binary: OUT_W too small for NTRITS");
    end

    bt_state_e               state, state_nxt;
    logic [IN_W-1:0]         hold, hold_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic signed [OUT_W-1:0] acc, acc_nxt;
    logic                    err, err_nxt;
    logic                    in_ready_nxt, out_valid_nxt, out_err_nxt;
    logic signed [OUT_W-1:0] out_value_nxt;
    logic signed [1:0]       trit_val;
    logic                    trit_inv;

    // Hold register shifts left so the current trit is always the top pair.
    bt_trit_decode u_dec (
        .code    (hold[IN_W-1 -: 2]),
        .value   (trit_val),
        .invalid (trit_inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            cnt       <= '0;
            acc       <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            err       <= err_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_value <= out_value_nxt;
            out_err   <= out_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        err_nxt       = err;
        out_value_nxt = out_value;
        out_err_nxt   = out_err;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    hold_nxt  = in_trits;
                    acc_nxt   = '0;
                    err_nxt   = 1'b0;
                    cnt_nxt   = CNT_W'(NTRITS - 1);
                    state_nxt = CONV;
                end
            end
            CONV: begin
                // Horner step: acc*3 + trit, with 3*acc formed as (acc<<1)+acc.
                acc_nxt  = (acc <<< 1) + acc + OUT_W'(trit_val);
                err_nxt  = err | trit_inv;
                hold_nxt = hold << 2;
                if (cnt == '0) begin
                    state_nxt     = DONE;
                    out_value_nxt = acc_nxt;
                    out_err_nxt   = err_nxt;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

endmodule

// File: doc/bt_result_to_binary.md
Name: bt_result_to_binary

Overview:
- Downstream stage of the balanced-ternary calculator core. Consumes its 4-trit result word, one 2-bit code per trit.
- Converts the word to a two's-complement binary integer by serial Horner evaluation, MSB trit first, one trit per clock.
- Flags any invalid trit code.
- Valid/ready on both sides; result feeds the binary display/debug path.

Parameters:
- NTRITS, 4, number of trits in the input word.
- OUT_W, 7, output width in bits. Must satisfy (3^NTRITS-1)/2 <= 2^(OUT_W-1)-1. Elaboration fails otherwise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream result word available.
- in_ready  out  1  block can accept a word.
- in_trits  in  2*NTRITS  result word. Trit k is at bits [2k+1:2k]; trit NTRITS-1 is the most significant.
- out_valid  out  1  converted value available.
- out_ready  in  1  downstream accepts the value.
- out_value  out  OUT_W  signed two's-complement value of the word.
- out_err  out  1  at least one trit in the word had code 2'b00.

Behaviour:
- Trit encoding:
  - 2'b01 = -1
  - 2'b11 = 0
  - 2'b10 = +1
  - 2'b00 = invalid; contributes 0 and sets the error flag.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_value=0, out_err=0, internal accumulator and counter 0.
- FSM has three states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture in_trits into a shift/hold register, clear accumulator and err, load counter=NTRITS-1, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: acc <= 3*acc + trit[counter]; err <= err | (trit[counter]==2'b00).
  - counter decrements. When counter==0 the update completes and the state goes to DONE.
  - Exactly NTRITS cycles in CONV.
- DONE:
  - out_valid=1; out_value=acc; out_err=err.
  - Outputs are held stable until out_ready=1. On that edge go to IDLE; out_valid drops the next cycle.
  - in_ready=0 in DONE, so there is no same-cycle accept on output handshake.
- Latency: a word accepted at edge E gives out_valid=1 in the cycle after edge E+NTRITS. Throughput is one word per NTRITS+2 cycles with out_ready held high.
- Arithmetic:
  - Accumulator is OUT_W signed bits.
  - 3*acc is computed as (acc<<1)+acc, sign-extended.
  - The parameter constraint guarantees no overflow. No saturation logic.
- Invalid trits do not abort conversion; the value is computed with the invalid trit taken as 0.
- rst asserted in any state, including mid-CONV or in DONE with a pending output: returns to IDLE with reset values next cycle. The in-flight word is discarded.
- in_trits is ignored except at the IDLE accept edge; changes during CONV have no effect.
- in_valid high in CONV/DONE is not consumed; upstream holds it.

Decomposition:
- Shared package bt_pkg:
  - trit code constants BT_NEG=2'b01, BT_ZERO=2'b11, BT_POS=2'b10, BT_INV=2'b00;
  - FSM state enum (IDLE, CONV, DONE).
- One sub-module, bt_trit_decode (combinational): 2-bit code in; signed 2-bit value (-1/0/+1) and invalid flag out.
- The top holds the FSM, counter, accumulator and capture register.

Test Plan:
- Reset then in_trits=8'b10101010 (+1,+1,+1,+1), in_valid pulse, out_ready=1 -> out_valid rises 4 cycles after accept; out_value=40; out_err=0.
- in_trits=8'b01010101 -> out_value=-40 (7'b1011000); out_err=0.
- in_trits=8'b10110111 (+1,0,-1,0) -> out_value=24. Then 8'b11111111 -> 0. Back-to-back words are accepted only after out_valid handshakes.
- in_trits=8'b00111110 (inv,0,0,+1) -> out_value=1; out_err=1. Next valid word -> out_err=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_value and out_err are stable; in_ready=0; a new in_valid is not consumed until after out_ready=1.
- rst pulsed on the 2nd CONV cycle -> next cycle in IDLE, in_ready=1, out_valid=0, out_value=0. A following word 8'b11111110 converts to 1 correctly.
